// File: rtl/draw_pixel_writer_if.sv
// -----------------------------------------------------------------------------
// draw_pixel_writer_if
//   Bundles the two handshakes of the pixel writer:
//     - pixel stream from the line rasteriser (pix_valid_i / pix_ready_o,
//       signed x_i / y_i, colour_i)
//     - VRAM write request channel (vram_req_o / vram_ack_i with word address,
//       replicated colour data and nibble write mask)
//   Signal names carry the direction suffix as seen from the pixel writer.
//   Modports:
//     slave  - the pixel writer itself (consumes pixels, issues writes)
//     master - the environment (rasteriser + VRAM controller side)
// -----------------------------------------------------------------------------
interface draw_pixel_writer_if #(
  parameter int CORDW = 10,
  parameter int ADDRW = 16
);
  // Pixel stream
  logic                    pix_valid_i;
  logic signed [CORDW-1:0] x_i;
  logic signed [CORDW-1:0] y_i;
  logic [3:0]              color_i;
  logic                    pix_ready_o;

  // VRAM write channel
  logic                    vram_req_o;
  logic [ADDRW-1:0]        vram_addr_o;
  logic [15:0]             vram_data_o;
  logic [3:0]              vram_mask_o;
  logic                    vram_ack_i;

  modport slave (
    input  pix_valid_i, x_i, y_i, color_i, vram_ack_i,
    output pix_ready_o, vram_req_o, vram_addr_o, vram_data_o, vram_mask_o
  );

  modport master (
    output pix_valid_i, x_i, y_i, color_i, vram_ack_i,
    input  pix_ready_o, vram_req_o, vram_addr_o, vram_data_o, vram_mask_o
  );
endinterface

// File: rtl/draw_pixel_writer.sv
// -----------------------------------------------------------------------------
// draw_pixel_writer
//   Takes the rasteriser's (x, y) pixel stream and writes it into a 4bpp
//   framebuffer. Each pixel is clipped to cfg_width_i x cfg_height_i, turned
//   into a 16-bit word address plus nibble mask, and issued as a VRAM write.
//   Consecutive same-colour pixels that fall into the word already waiting for
//   an ack are folded into that write by widening its mask.
//
//   Pipeline: S1 (pixel register) -> OUT (pending VRAM request).
//
// Ports:
//   clk, reset_n_i      clock, asynchronous active-low reset
//   cfg_base_i          framebuffer base word address
//   cfg_stride_i        words per framebuffer line
//   cfg_width_i/height  visible area in pixels (unsigned)
//   clip_clr_i          synchronous clear of clip_count_o (wins over increment)
//   clip_count_o        saturating count of clipped pixels
//   busy_o              a pixel is in S1 or a write is pending
//   bus                 pixel stream + VRAM write channel (slave modport)
// -----------------------------------------------------------------------------
module draw_pixel_writer #(
  parameter int CORDW = 10,
  parameter int ADDRW = 16
) (
  input  logic             clk,
  input  logic             reset_n_i,
  input  logic [ADDRW-1:0] cfg_base_i,
  input  logic [7:0]       cfg_stride_i,
  input  logic [CORDW-1:0] cfg_width_i,
  input  logic [CORDW-1:0] cfg_height_i,
  input  logic             clip_clr_i,
  output logic [15:0]      clip_count_o,
  output logic             busy_o,
  draw_pixel_writer_if.slave bus
);

  localparam int PRODW = CORDW + 8;

  // S1 pixel register
  logic             s1_valid_q, s1_valid_d;
  logic [CORDW-1:0] s1_x_q,     s1_x_d;
  logic [CORDW-1:0] s1_y_q,     s1_y_d;
  logic [3:0]       s1_color_q, s1_color_d;
  logic             s1_inb_q,   s1_inb_d;

  // OUT request register
  logic             req_q,  req_d;
  logic [ADDRW-1:0] addr_q, addr_d;
  logic [15:0]      data_q, data_d;
  logic [3:0]       mask_q, mask_d;

  logic [15:0]      clip_q, clip_d;

  // Combinational helpers
  logic             in_bounds;
  logic [PRODW-1:0] s1_prod;
  logic [ADDRW-1:0] s1_addr;
  logic [3:0]       s1_mask;
  logic             ack_eff;
  logic             merge;
  logic             s1_adv;
  logic             accept;

  // Bounds check on the incoming pixel: sign bit rejects negatives, the
  // limits are compared as unsigned quantities.
  assign in_bounds = !bus.x_i[CORDW-1] && !bus.y_i[CORDW-1] &&
                     ($unsigned(bus.x_i) < cfg_width_i) &&
                     ($unsigned(bus.y_i) < cfg_height_i);

  // Word address of the pixel in S1. The line offset is formed at full
  // product width and the sum wraps modulo 2^ADDRW, so a base near the top
  // of the address space rolls over to zero.
  assign s1_prod = PRODW'(s1_y_q) * PRODW'(cfg_stride_i);
  assign s1_addr = cfg_base_i + ADDRW'(s1_prod) + ADDRW'(s1_x_q >> 2);
  assign s1_mask = 4'b1000 >> s1_x_q[1:0];

  // An ack only counts while a request is actually outstanding.
  assign ack_eff = req_q && bus.vram_ack_i;

  // Merging is disabled on the ack edge: the word is leaving, so a matching
  // pixel becomes a fresh request instead of widening a consumed one.
  assign merge  = s1_valid_q && s1_inb_q && req_q && !bus.vram_ack_i &&
                  (s1_addr == addr_q) && (s1_color_q == data_q[3:0]);

  assign s1_adv = s1_valid_q && (!s1_inb_q || !req_q || ack_eff || merge);

  assign bus.pix_ready_o = !s1_valid_q || s1_adv;
  assign accept          = bus.pix_valid_i && bus.pix_ready_o;

  // NOTE: every signal written here gets a default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_x_d     = s1_x_q;
    s1_y_d     = s1_y_q;
    s1_color_d = s1_color_q;
    s1_inb_d   = s1_inb_q;
    req_d      = req_q;
    addr_d     = addr_q;
    data_d     = data_q;
    mask_d     = mask_q;
    clip_d     = clip_q;

    // S1: load on accept, otherwise empty when it advances.
    if (accept) begin
      s1_valid_d = 1'b1;
      s1_x_d     = bus.x_i;
      s1_y_d     = bus.y_i;
      s1_color_d = bus.color_i;
      s1_inb_d   = in_bounds;
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end

    // OUT: retire on ack, then either widen (merge) or reload from S1.
    if (ack_eff) begin
      req_d = 1'b0;
    end
    if (s1_valid_q && s1_inb_q) begin
      if (merge) begin
        mask_d = mask_q | s1_mask;
      end else if (!req_q || ack_eff) begin
        req_d  = 1'b1;
        addr_d = s1_addr;
        data_d = {4{s1_color_q}};
        mask_d = s1_mask;
      end
    end

    // Clip counter: clear wins over a same-cycle increment; saturates.
    if (clip_clr_i) begin
      clip_d = '0;
    end else if (s1_valid_q && !s1_inb_q && (clip_q != 16'hFFFF)) begin
      clip_d = clip_q + 16'd1;
    end
  end

  // NOTE: the request payload registers are reset along with the control
  // bits because their reset value (zero) is visible on the VRAM bus.
  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      s1_valid_q <= 1'b0;
      s1_x_q     <= '0;
      s1_y_q     <= '0;
      s1_color_q <= '0;
      s1_inb_q   <= 1'b0;
      req_q      <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      mask_q     <= '0;
      clip_q     <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      s1_valid_q <= s1_valid_d;
      s1_x_q     <= s1_x_d;
      s1_y_q     <= s1_y_d;
      s1_color_q <= s1_color_d;
      s1_inb_q   <= s1_inb_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      mask_q     <= mask_d;
      clip_q     <= clip_d;
    end
  end

  assign bus.vram_req_o  = req_q;
  assign bus.vram_addr_o = addr_q;
  assign bus.vram_data_o = data_q;
  assign bus.vram_mask_o = mask_q;
  assign clip_count_o    = clip_q;
  assign busy_o          = s1_valid_q || req_q;

endmodule

// File: tb/tb_draw_pixel_writer.sv
// -----------------------------------------------------------------------------
// tb_draw_pixel_writer
//   Directed scenarios plus a randomized run. The random run paints a
//   reference framebuffer pixel by pixel (with clipping) and compares it with
//   the framebuffer rebuilt from the VRAM writes the DUT issued.
//   An automatic VRAM responder acks requests after a programmable delay.
// -----------------------------------------------------------------------------
module tb_draw_pixel_writer;
  localparam int CORDW = 10;
  localparam int ADDRW = 16;

  typedef struct {
    logic [ADDRW-1:0] addr;
    logic [15:0]      data;
    logic [3:0]       mask;
  } wr_t;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [ADDRW-1:0] cfg_base;
  logic [7:0]       cfg_stride;
  logic [CORDW-1:0] cfg_width;
  logic [CORDW-1:0] cfg_height;
  logic             clip_clr;
  logic [15:0]      clip_count;
  logic             busy;

  draw_pixel_writer_if #(.CORDW(CORDW), .ADDRW(ADDRW)) bus ();

  draw_pixel_writer #(.CORDW(CORDW), .ADDRW(ADDRW)) dut (
    .clk          (clk),
    .reset_n_i    (reset_n),
    .cfg_base_i   (cfg_base),
    .cfg_stride_i (cfg_stride),
    .cfg_width_i  (cfg_width),
    .cfg_height_i (cfg_height),
    .clip_clr_i   (clip_clr),
    .clip_count_o (clip_count),
    .busy_o       (busy),
    .bus          (bus)
  );

  always #5 clk = ~clk;

  int  n_checks = 0;
  int  n_fail   = 0;
  int  n_stalls = 0;
  int  ack_delay = 0;
  bit  ack_hold  = 1'b0;
  int  ack_cnt   = 0;
  wr_t wq[$];

  // Handshake monitor state
  logic             p_req;
  logic [ADDRW-1:0] p_addr;
  logic [15:0]      p_data;
  logic [3:0]       p_mask;

  // VRAM responder and handshake monitor. At a negedge, vram_ack_i still
  // holds the value the DUT saw at the preceding posedge.
  always @(negedge clk) begin
    if (!reset_n) begin
      bus.vram_ack_i = 1'b0;
      ack_cnt        = 0;
      p_req          = 1'b0;
    end else begin
      if (p_req && !bus.vram_ack_i) begin
        n_checks++;
        if (bus.vram_req_o !== 1'b1 || bus.vram_addr_o !== p_addr ||
            bus.vram_data_o !== p_data || (bus.vram_mask_o & p_mask) !== p_mask) begin
          n_fail++;
          $display("FAIL handshake_stable: req=%b addr=%h data=%h mask=%b, need req=1 addr=%h data=%h mask covering %b",
                   bus.vram_req_o, bus.vram_addr_o, bus.vram_data_o, bus.vram_mask_o, p_addr, p_data, p_mask);
        end
      end
      p_req  = bus.vram_req_o;
      p_addr = bus.vram_addr_o;
      p_data = bus.vram_data_o;
      p_mask = bus.vram_mask_o;

      if (bus.vram_ack_i) begin
        bus.vram_ack_i = 1'b0;
        ack_cnt        = 0;
      end else if (bus.vram_req_o && !ack_hold) begin
        if (ack_cnt >= ack_delay) begin
          bus.vram_ack_i = 1'b1;
          wq.push_back('{addr: bus.vram_addr_o, data: bus.vram_data_o, mask: bus.vram_mask_o});
        end else begin
          ack_cnt++;
        end
      end
    end
  end

  // Expected word address from the framebuffer layout, plain integer math.
  function automatic logic [15:0] exp_addr(input int base, input int stride, input int x, input int y);
    int a;
    a = (base + y * stride + x / 4) % 65536;
    return a[15:0];
  endfunction

  task automatic set_cfg(input int base, input int stride, input int w, input int h);
    cfg_base   = base[ADDRW-1:0];
    cfg_stride = stride[7:0];
    cfg_width  = w[CORDW-1:0];
    cfg_height = h[CORDW-1:0];
  endtask

  // Presents one pixel from a negedge and returns just after the posedge on
  // which it was accepted.
  task automatic send_pix(input int px, input int py, input logic [3:0] c);
    bit done = 1'b0;
    @(negedge clk);
    bus.pix_valid_i = 1'b1;
    bus.x_i         = px[CORDW-1:0];
    bus.y_i         = py[CORDW-1:0];
    bus.color_i     = c;
    for (int i = 0; i < 300 && !done; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      if (bus.pix_ready_o === 1'b1) begin
        @(posedge clk);
        done = 1'b1;
      end else begin
        n_stalls++;
      end
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: pixel (%0d,%0d) not accepted within 300 cycles", px, py);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    bus.pix_valid_i = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 500 && !ok; i++) begin
      @(negedge clk);
      #1;
      if (!busy && !bus.vram_ack_i) ok = 1'b1;
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL idle_timeout: busy=%b req=%b still active after 500 cycles", busy, bus.vram_req_o);
    end
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    clip_clr = 1'b1;
    @(negedge clk);
    clip_clr = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if (bus.vram_req_o !== 1'b0 || busy !== 1'b0 || clip_count !== 16'h0 || bus.pix_ready_o !== 1'b1 ||
        bus.vram_addr_o !== 16'h0 || bus.vram_data_o !== 16'h0 || bus.vram_mask_o !== 4'h0) begin
      n_fail++;
      $display("FAIL reset_state: req=%b busy=%b clip=%h ready=%b addr=%h data=%h mask=%b, want 0 0 0000 1 0000 0000 0000",
               bus.vram_req_o, busy, clip_count, bus.pix_ready_o, bus.vram_addr_o, bus.vram_data_o, bus.vram_mask_o);
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_single();
    set_cfg('h1000, 80, 320, 240);
    ack_delay = 0;
    ack_hold  = 1'b0;
    wq.delete();
    send_pix(0, 0, 4'h5);
    idle();
    #1;
    n_checks++;
    if (bus.vram_req_o !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL single_lat1: req=%b busy=%b, want req=0 busy=1", bus.vram_req_o, busy);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (bus.vram_req_o !== 1'b1 || bus.vram_addr_o !== 16'h1000 || bus.vram_mask_o !== 4'b1000 ||
        bus.vram_data_o !== 16'h5555) begin
      n_fail++;
      $display("FAIL single_req: req=%b addr=%h mask=%b data=%h, want 1 1000 1000 5555",
               bus.vram_req_o, bus.vram_addr_o, bus.vram_mask_o, bus.vram_data_o);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (bus.vram_req_o !== 1'b0 || busy !== 1'b0 || wq.size() != 1) begin
      n_fail++;
      $display("FAIL single_done: req=%b busy=%b writes=%0d, want 0 0 1", bus.vram_req_o, busy, wq.size());
    end
  endtask

  task automatic test_merge();
    wr_t exp[$];
    set_cfg('h1000, 80, 320, 240);
    ack_delay = 0;
    ack_hold  = 1'b1;
    wq.delete();
    for (int i = 4; i < 8; i++) send_pix(i, 1, 4'h5);
    idle();
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if (bus.vram_req_o !== 1'b1 || bus.vram_addr_o !== exp_addr('h1000, 80, 4, 1) ||
        bus.vram_mask_o !== 4'b1111 || bus.vram_data_o !== 16'h5555) begin
      n_fail++;
      $display("FAIL merge_word: req=%b addr=%h mask=%b data=%h, want 1 1051 1111 5555",
               bus.vram_req_o, bus.vram_addr_o, bus.vram_mask_o, bus.vram_data_o);
    end
    send_pix(8, 1, 4'h5);
    idle();
    #1;
    n_checks++;
    if (bus.pix_ready_o !== 1'b0) begin
      n_fail++;
      $display("FAIL merge_backpressure: pix_ready=%b, want 0", bus.pix_ready_o);
    end
    ack_hold = 1'b0;
    wait_idle();
    exp.push_back('{addr: 16'h1051, data: 16'h5555, mask: 4'b1111});
    exp.push_back('{addr: 16'h1052, data: 16'h5555, mask: 4'b1000});
    n_checks++;
    if (wq.size() != exp.size()) begin
      n_fail++;
      $display("FAIL merge_count: writes=%0d, want %0d", wq.size(), exp.size());
    end else begin
      foreach (exp[i]) begin
        n_checks++;
        if (wq[i] !== exp[i]) begin
          n_fail++;
          $display("FAIL merge_write%0d: addr=%h data=%h mask=%b, want %h %h %b", i,
                   wq[i].addr, wq[i].data, wq[i].mask, exp[i].addr, exp[i].data, exp[i].mask);
        end
      end
    end
  endtask

  task automatic test_clip();
    set_cfg('h1000, 80, 320, 240);
    ack_delay = 0;
    ack_hold  = 1'b0;
    wq.delete();
    pulse_clr();
    send_pix(-1, 3, 4'h2);
    send_pix(320, 0, 4'h2);
    send_pix(0, 240, 4'h2);
    idle();
    wait_idle();
    n_checks++;
    if (clip_count !== 16'd3 || wq.size() != 0) begin
      n_fail++;
      $display("FAIL clip_count: clip=%0d writes=%0d, want 3 0", clip_count, wq.size());
    end
    pulse_clr();
    #1;
    n_checks++;
    if (clip_count !== 16'd0) begin
      n_fail++;
      $display("FAIL clip_clear: clip=%0d, want 0", clip_count);
    end
    // Clip and clear land on the same edge.
    send_pix(-1, 0, 4'h2);
    @(negedge clk);
    bus.pix_valid_i = 1'b0;
    clip_clr        = 1'b1;
    @(negedge clk);
    clip_clr = 1'b0;
    #1;
    n_checks++;
    if (clip_count !== 16'd0) begin
      n_fail++;
      $display("FAIL clip_clr_priority: clip=%0d, want 0", clip_count);
    end
    // A large negative x must still clip when the width exceeds its
    // unsigned image.
    set_cfg('h1000, 80, 1000, 1000);
    send_pix(-500, 0, 4'h2);
    idle();
    wait_idle();
    n_checks++;
    if (clip_count !== 16'd1 || wq.size() != 0) begin
      n_fail++;
      $display("FAIL clip_negative: clip=%0d writes=%0d, want 1 0", clip_count, wq.size());
    end
  endtask

  task automatic test_back_to_back();
    set_cfg('h1000, 80, 320, 240);
    ack_delay = 5;
    ack_hold  = 1'b0;
    n_stalls  = 0;
    wq.delete();
    for (int i = 0; i < 3; i++) send_pix(0, i, 4'h5);
    idle();
    n_checks++;
    if (n_stalls == 0) begin
      n_fail++;
      $display("FAIL b2b_stall: pix_ready never low (stalls=%0d), want >0", n_stalls);
    end
    wait_idle();
    n_checks++;
    if (wq.size() != 3) begin
      n_fail++;
      $display("FAIL b2b_count: writes=%0d, want 3", wq.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (wq[i].addr !== exp_addr('h1000, 80, 0, i) || wq[i].mask !== 4'b1000 || wq[i].data !== 16'h5555) begin
          n_fail++;
          $display("FAIL b2b_write%0d: addr=%h mask=%b data=%h, want %h 1000 5555", i,
                   wq[i].addr, wq[i].mask, wq[i].data, exp_addr('h1000, 80, 0, i));
        end
      end
    end
  endtask

  task automatic test_wrap();
    wr_t exp[$];
    set_cfg('hFFF0, 80, 320, 240);
    ack_delay = 0;
    ack_hold  = 1'b0;
    wq.delete();
    send_pix(8, 0, 4'h5);
    send_pix(0, 1, 4'h5);
    idle();
    wait_idle();
    set_cfg('h1000, 80, 320, 240);
    ack_hold = 1'b1;
    send_pix(0, 0, 4'h3);
    send_pix(1, 0, 4'h7);
    idle();
    repeat (3) @(negedge clk);
    ack_hold = 1'b0;
    wait_idle();
    exp.push_back('{addr: 16'hFFF2, data: 16'h5555, mask: 4'b1000});
    exp.push_back('{addr: 16'h0040, data: 16'h5555, mask: 4'b1000});
    exp.push_back('{addr: 16'h1000, data: 16'h3333, mask: 4'b1000});
    exp.push_back('{addr: 16'h1000, data: 16'h7777, mask: 4'b0100});
    n_checks++;
    if (wq.size() != exp.size()) begin
      n_fail++;
      $display("FAIL wrap_count: writes=%0d, want %0d", wq.size(), exp.size());
    end else begin
      foreach (exp[i]) begin
        n_checks++;
        if (wq[i] !== exp[i]) begin
          n_fail++;
          $display("FAIL wrap_write%0d: addr=%h data=%h mask=%b, want %h %h %b", i,
                   wq[i].addr, wq[i].data, wq[i].mask, exp[i].addr, exp[i].data, exp[i].mask);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    set_cfg('h1000, 80, 320, 240);
    ack_delay = 0;
    ack_hold  = 1'b1;
    pulse_clr();
    send_pix(-1, -1, 4'h1);
    send_pix(2, 2, 4'h6);
    idle();
    repeat (3) @(negedge clk);
    #1;
    n_checks++;
    if (bus.vram_req_o !== 1'b1 || clip_count !== 16'd1) begin
      n_fail++;
      $display("FAIL areset_pre: req=%b clip=%0d, want 1 1", bus.vram_req_o, clip_count);
    end
    #1;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (bus.vram_req_o !== 1'b0 || busy !== 1'b0 || clip_count !== 16'd0 || bus.pix_ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL areset_drop: req=%b busy=%b clip=%0d ready=%b, want 0 0 0 1",
               bus.vram_req_o, busy, clip_count, bus.pix_ready_o);
    end
    @(negedge clk);
    ack_hold = 1'b0;
    wq.delete();
    @(negedge clk);
    reset_n = 1'b1;
    send_pix(3, 0, 4'h9);
    idle();
    wait_idle();
    n_checks++;
    if (wq.size() != 1 || wq[0].addr !== 16'h1000 || wq[0].mask !== 4'b0001 || wq[0].data !== 16'h9999) begin
      n_fail++;
      $display("FAIL areset_after: writes=%0d first addr=%h mask=%b data=%h, want 1 1000 0001 9999",
               wq.size(), (wq.size() > 0) ? wq[0].addr : 16'hx, (wq.size() > 0) ? wq[0].mask : 4'hx,
               (wq.size() > 0) ? wq[0].data : 16'hx);
    end
  endtask

  task automatic test_random();
    logic [3:0] ref_fb [0:7][0:15];
    logic [3:0] dut_fb [0:7][0:15];
    int exp_clip = 0;
    int px, py, off, xx, yy;
    logic [3:0] c;
    set_cfg('h0200, 4, 16, 8);
    ack_hold = 1'b0;
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 16; x++) begin
        ref_fb[y][x] = 4'h0;
        dut_fb[y][x] = 4'h0;
      end
    pulse_clr();
    wq.delete();
    for (int k = 0; k < 300; k++) begin
      px = int'($urandom_range(0, 23)) - 4;
      py = int'($urandom_range(0, 11)) - 2;
      c  = 4'($urandom_range(1, 3));
      ack_delay = int'($urandom_range(0, 3));
      if (px >= 0 && px < 16 && py >= 0 && py < 8) ref_fb[py][px] = c;
      else exp_clip++;
      send_pix(px, py, c);
      if ($urandom_range(0, 3) == 0) idle();
    end
    idle();
    wait_idle();
    n_checks++;
    if (clip_count !== 16'(exp_clip)) begin
      n_fail++;
      $display("FAIL rand_clip: clip=%0d, want %0d", clip_count, exp_clip);
    end
    foreach (wq[i]) begin
      off = int'(wq[i].addr) - 'h200;
      n_checks++;
      if (off < 0 || off >= 32) begin
        n_fail++;
        $display("FAIL rand_addr_range: write %0d addr=%h, want 0200..021f", i, wq[i].addr);
      end else begin
        for (int b = 0; b < 4; b++) begin
          if (wq[i].mask[b]) begin
            xx = (off % 4) * 4 + (3 - b);
            yy = off / 4;
            dut_fb[yy][xx] = wq[i].data[b*4 +: 4];
          end
        end
      end
    end
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 16; x++) begin
        n_checks++;
        if (dut_fb[y][x] !== ref_fb[y][x]) begin
          n_fail++;
          $display("FAIL rand_pixel(%0d,%0d): got %h, want %h", x, y, dut_fb[y][x], ref_fb[y][x]);
        end
      end
  endtask

  initial begin
    bus.pix_valid_i = 1'b0;
    bus.x_i         = '0;
    bus.y_i         = '0;
    bus.color_i     = '0;
    clip_clr        = 1'b0;
    set_cfg('h1000, 80, 320, 240);
    test_reset();
    test_single();
    test_merge();
    test_clip();
    test_back_to_back();
    test_wrap();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/draw_pixel_writer.md
Name: draw_pixel_writer

Overview:
- Downstream stage of the line rasteriser: consumes its (x, y) pixel stream and writes the pixels into 4bpp framebuffer VRAM.
- Clips each pixel to the framebuffer, converts (x, y) to a 16-bit word address and nibble mask, and issues VRAM write requests over a req/ack handshake.
- Merges consecutive pixels that land in the same word into one write.
- Provides backpressure through pix_ready_o, which drives the rasteriser's output-enable.

Parameters:
CORDW, 10, coordinate width in bits (signed inputs)
ADDRW, 16, VRAM word address width

Ports:
clk  in  1  clock
reset_n_i  in  1  asynchronous active-low reset
cfg_base_i  in  ADDRW  framebuffer base word address
cfg_stride_i  in  8  words per line
cfg_width_i  in  CORDW  visible width in pixels (unsigned)
cfg_height_i  in  CORDW  visible height in pixels (unsigned)
color_i  in  4  pixel colour, sampled with each accepted pixel
pix_valid_i  in  1  pixel present (from rasteriser drawing_o)
x_i, y_i  in  CORDW each  signed pixel coordinate
pix_ready_o  out  1  pixel accepted this cycle when high with pix_valid_i (to rasteriser oe_i)
vram_req_o  out  1  write request pending
vram_addr_o  out  ADDRW  write word address
vram_data_o  out  16  write data, {4{colour}}
vram_mask_o  out  4  nibble write enables; bit 3 = nibble [15:12] = leftmost pixel
vram_ack_i  in  1  one-cycle pulse: current request consumed
clip_clr_i  in  1  synchronous clear of clip_count_o
clip_count_o  out  16  saturating count of clipped pixels
busy_o  out  1  S1 valid or vram_req_o high

Behaviour:
- Reset (async, reset_n_i low): S1 empty, vram_req_o=0, addr/data/mask=0, clip_count_o=0, busy_o=0. pix_ready_o=1 (combinational from the empty state). Reset mid-request drops vram_req_o immediately; the pending write is discarded.
- Pipeline has two registers: S1 (x, y, colour, in_bounds) and OUT (req/addr/data/mask).
- Accept: a pixel is accepted when pix_valid_i && pix_ready_o. S1 loads on that edge.
- pix_ready_o = !S1.valid || s1_adv.
- in_bounds = x>=0 && y>=0 && x<cfg_width_i && y<cfg_height_i. Compares are signed against zero and unsigned against the limits.
- s1_adv (S1 empties this edge) is true if any of:
  - S1 is out of bounds: dropped, clip_count_o increments, saturating at 0xFFFF.
  - OUT is empty.
  - vram_ack_i is high.
  - merge is true.
- Merge: OUT valid && !vram_ack_i && S1 in bounds && S1 addr == vram_addr_o && S1 colour == current OUT colour. On merge, vram_mask_o |= S1 mask. Address and data are unchanged, and req stays high.
- If ack and a same-address pixel coincide, there is no merge; S1 loads OUT as a new request.
- OUT load (in bounds, not merged):
  - addr = cfg_base_i + y*cfg_stride_i + (x>>2). The product is computed at 18 bits, then the result is truncated modulo 2^ADDRW, so base wrap-around is allowed.
  - mask = 4'b1000 >> x[1:0].
  - data = {4{colour}}.
- Latency: pixel accepted at edge N → vram_req_o high after edge N+1, when OUT is free.
- Handshake:
  - vram_req_o stays high with stable addr/data until the edge on which vram_ack_i is sampled high.
  - The mask may only grow, via merge, and only while ack is low.
  - vram_ack_i is ignored while vram_req_o is low.
- Backpressure: with OUT stalled and S1 holding a non-mergeable in-bounds pixel, pix_ready_o=0. No pixel is lost or reordered.
- clip_clr_i has priority over an increment in the same cycle; the result is 0.
- cfg_* must be stable while busy_o is high; the block does not check this.
- busy_o = S1.valid || vram_req_o.

Test Plan:
1. base=0x1000, stride=80, w=320, h=240, colour=5. Pixel (0,0) with ack 1 cycle after req → req 2 edges after accept, addr 0x1000, mask 1000, data 0x5555. busy_o falls after ack.
2. Pixels (4,1),(5,1),(6,1),(7,1) back-to-back, ack held low until all accepted → one write: addr 0x1051, mask 1111. A subsequent (8,1) → separate write at addr 0x1052, mask 1000.
3. Pixels (-1,3),(320,0),(0,240) → no vram_req_o, clip_count_o=3. Then clip_clr_i → 0. Clip with clear in the same cycle → 0.
4. Pixels (0,0),(0,1),(0,2) with ack delayed 5 cycles each → pix_ready_o low while stalled. Writes appear in order at 0x1000, 0x1050, 0x10A0, each mask 1000; none lost.
5. Wrap cases:
   - base=0xFFF0, (8,0) → addr 0xFFF2.
   - base=0xFFF0, stride=80, (0,1) → addr 0x0040.
   - Same-word pixel with a different colour → not merged, two writes.
6. Assert reset_n_i low while vram_req_o pending → vram_req_o, busy_o, clip_count_o go 0 without a clock edge. After release, pix_ready_o=1 and the next pixel writes normally.
